lcd_bus_driver: RTL and testbench

- Downstream of the LCD text/command sequencer. It takes one 9-bit LCD transfer at a time over an iStart/oDone handshake.
- It generates the HD44780-class parallel bus cycle: address setup, enable pulse, data hold.
- It then waits out the instruction execution time before reporting completion, so the upstream sequencer needs no delay counter of its own.
- Write-only: LCD_RW is tied low and the busy flag is never read.

---
 rtl/lcd_bus_driver.sv | 156 +++++++++++++++
 tb/tb_lcd_bus_driver.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_driver.sv
// HD44780-style write-only bus cycle generator: setup, enable pulse, hold, then
// waits out the instruction execution time before pulsing oDone.
module lcd_bus_driver #(
    parameter int SETUP_CYC      = 2,
    parameter int EN_HIGH_CYC    = 16,
    parameter int HOLD_CYC       = 2,
    parameter int EXEC_SHORT_CYC = 2000,
    parameter int EXEC_LONG_CYC  = 82000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oDone,
    output logic       oBusy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    localparam int MAX_A   = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
    localparam int MAX_B   = (HOLD_CYC > EXEC_SHORT_CYC) ? HOLD_CYC : EXEC_SHORT_CYC;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_C > EXEC_LONG_CYC) ? MAX_C : EXEC_LONG_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LOAD    = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] SHORT_LOAD = CW'(EXEC_SHORT_CYC - 1);
    localparam logic [CW-1:0] LONG_LOAD  = CW'(EXEC_LONG_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HI,
        HOLD,
        EXEC,
        DONE
    } state_t;

    state_t        stateReg, stateNext;
    logic [CW-1:0] cntReg, cntNext;
    logic          armedReg, armedNext;
    logic          longReg, longNext;
    logic [7:0]    dataReg, dataNext;
    logic          rsReg, rsNext;
    logic          enReg, doneReg, busyReg;
    logic          accept, cmdIsLong;

    always_comb begin
        accept    = (stateReg == IDLE) && iStart && armedReg;
        // Clear Display (0x01) and Return Home (0x02/0x03) need the long wait
        cmdIsLong = !iRS && (iDATA[7:2] == 6'd0) && (iDATA != 8'd0);

        stateNext = stateReg;
        cntNext   = cntReg;
        longNext  = longReg;
        dataNext  = dataReg;
        rsNext    = rsReg;
        armedNext = armedReg;

        if (accept) begin
            armedNext = 1'b0;
        end else if (!iStart) begin
            armedNext = 1'b1;
        end

        unique case (stateReg)
            IDLE: begin
                if (accept) begin
                    stateNext = SETUP;
                    cntNext   = SETUP_LOAD;
                    dataNext  = iDATA;
                    rsNext    = iRS;
                    longNext  = cmdIsLong;
                end
            end
            SETUP: begin
                if (cntReg == '0) begin
                    stateNext = EN_HI;
                    cntNext   = EN_LOAD;
                end else begin
                    cntNext = cntReg - CW'(1);
                end
            end
            EN_HI: begin
                if (cntReg == '0) begin
                    stateNext = HOLD;
                    cntNext   = HOLD_LOAD;
                end else begin
                    cntNext = cntReg - CW'(1);
                end
            end
            HOLD: begin
                if (cntReg == '0) begin
                    stateNext = EXEC;
                    cntNext   = longReg ? LONG_LOAD : SHORT_LOAD;
                end else begin
                    cntNext = cntReg - CW'(1);
                end
            end
            EXEC: begin
                if (cntReg == '0) begin
                    stateNext = DONE;
                    cntNext   = '0;
                end else begin
                    cntNext = cntReg - CW'(1);
                end
            end
            DONE: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // Strobe/status flops are fed from the next state so they align with the state register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stateReg <= IDLE;
            cntReg   <= '0;
            armedReg <= 1'b1;
            longReg  <= 1'b0;
            dataReg  <= 8'd0;
            rsReg    <= 1'b0;
            enReg    <= 1'b0;
            doneReg  <= 1'b0;
            busyReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            armedReg <= armedNext;
            longReg  <= longNext;
            dataReg  <= dataNext;
            rsReg    <= rsNext;
            enReg    <= (stateNext == EN_HI);
            doneReg  <= (stateNext == DONE);
            busyReg  <= (stateNext != IDLE);
        end
    end

    assign LCD_DATA = dataReg;
    assign LCD_RS   = rsReg;
    assign LCD_EN   = enReg;
    assign LCD_RW   = 1'b0;
    assign oDone    = doneReg;
    assign oBusy    = busyReg;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Scoreboard bench for lcd_bus_driver: expectations are queued at request time
// and checked by a monitor when LCD_EN pulses and oDone appear.
module tb_lcd_bus_driver;

    localparam int SETUP = 2;
    localparam int ENH   = 4;
    localparam int HOLD  = 2;
    localparam int ES    = 10;
    localparam int EL    = 40;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic [7:0] iDATA = 8'h00;
    logic       iRS = 1'b0;
    logic       iStart = 1'b0;
    logic       oDone, oBusy, LCD_RW, LCD_EN, LCD_RS;
    logic [7:0] LCD_DATA;

    lcd_bus_driver #(
        .SETUP_CYC(SETUP),
        .EN_HIGH_CYC(ENH),
        .HOLD_CYC(HOLD),
        .EXEC_SHORT_CYC(ES),
        .EXEC_LONG_CYC(EL)
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .iDATA(iDATA),
        .iRS(iRS),
        .iStart(iStart),
        .oDone(oDone),
        .oBusy(oBusy),
        .LCD_DATA(LCD_DATA),
        .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN),
        .LCD_RS(LCD_RS)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [7:0] d;
        logic       rs;
        bit         lng;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   enPulses = 0;
    int   doneCount = 0;

    function automatic bit is_long(logic [7:0] d, logic rs);
        return !rs && (d inside {8'h01, 8'h02, 8'h03});
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Raise the request in the current cycle; DUT must be idle and armed
    task automatic start(logic [7:0] d, logic rs);
        exp_t e;
        iDATA  = d;
        iRS    = rs;
        iStart = 1'b1;
        e.t    = cyc;
        e.d    = d;
        e.rs   = rs;
        e.lng  = is_long(d, rs);
        sbq.push_back(e);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (oDone === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Monitor: timing of each EN pulse and oDone against the queued expectation
    initial begin : monitor
        logic [8:0] bus, prevBus, busAtFall;
        logic       prevEn, rstPrev;
        int         stable, enLen, want;
        exp_t       e;
        prevBus = '0; busAtFall = '0; prevEn = 1'b0; rstPrev = 1'b0;
        stable = 0; enLen = 0;
        forever begin
            @(negedge iCLK);
            bus = {LCD_RS, LCD_DATA};
            if (bus === prevBus) stable++;
            else stable = 0;
            prevBus = bus;
            if (LCD_EN === 1'b1 && !prevEn) begin
                enPulses++;
                enLen = 0;
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL en_rise_unexpected cyc=%0d", cyc);
                end else if (cyc !== sbq[0].t + 1 + SETUP || stable < 2 ||
                             bus !== {sbq[0].rs, sbq[0].d}) begin
                    failures++;
                    $display("FAIL en_rise got cyc=%0d stable=%0d bus=%h required cyc=%0d stable>=2 bus=%h",
                             cyc, stable, bus, sbq[0].t + 1 + SETUP, {sbq[0].rs, sbq[0].d});
                end
            end
            if (LCD_EN === 1'b1) enLen++;
            if (LCD_EN === 1'b0 && prevEn && !rstPrev) begin
                checks++;
                busAtFall = bus;
                if (enLen !== ENH) begin
                    failures++;
                    $display("FAIL en_width got=%0d required=%0d", enLen, ENH);
                end
            end
            prevEn  = (LCD_EN === 1'b1);
            rstPrev = iRST;
            if (oDone === 1'b1) begin
                doneCount++;
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected cyc=%0d", cyc);
                end else begin
                    e = sbq.pop_front();
                    want = e.t + 1 + SETUP + ENH + HOLD + (e.lng ? EL : ES);
                    if (cyc !== want || bus !== {e.rs, e.d} || busAtFall !== bus) begin
                        failures++;
                        $display("FAIL done got cyc=%0d bus=%h atfall=%h required cyc=%0d bus=%h",
                                 cyc, bus, busAtFall, want, {e.rs, e.d});
                    end
                end
            end
        end
    end

    task automatic test_reset();
        bit ok;
        iRST = 1'b1; iStart = 1'b1; iDATA = 8'h41; iRS = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({LCD_DATA, LCD_RS, LCD_EN, LCD_RW, oDone, oBusy} !== 13'd0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%h required=0", cyc,
                         {LCD_DATA, LCD_RS, LCD_EN, LCD_RW, oDone, oBusy});
            end
        end
        start(8'h41, 1'b1);
        iRST = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL reset_release_done got=timeout required=done"); end
        iStart = 1'b0;
        tick();
    endtask

    task automatic test_data_write();
        bit busyOk = 1'b1;
        start(8'h41, 1'b1);
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (oBusy !== 1'b1) busyOk = 1'b0;
            if (k == 1) begin
                checks++;
                if (LCD_DATA !== 8'h41 || LCD_RS !== 1'b1) begin
                    failures++;
                    $display("FAIL dw_latch got=%h/%b required=41/1", LCD_DATA, LCD_RS);
                end
            end
        end
        checks++;
        if (!busyOk) begin failures++; $display("FAIL dw_busy got=low_in_window required=high T+1..T+19"); end
        iStart = 1'b0;
        tick();
        checks++;
        if (oBusy !== 1'b0 || LCD_EN !== 1'b0 || oDone !== 1'b0 || LCD_DATA !== 8'h41) begin
            failures++;
            $display("FAIL dw_after got busy=%b en=%b done=%b data=%h required 0/0/0/41",
                     oBusy, LCD_EN, oDone, LCD_DATA);
        end
    endtask

    task automatic test_exec_length();
        logic [7:0] dTab[5]  = '{8'h01, 8'h01, 8'h03, 8'h04, 8'h02};
        logic       rsTab[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bit ok;
        for (int i = 0; i < 5; i++) begin
            start(dTab[i], rsTab[i]);
            wait_done(ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL exec_done idx=%0d got=timeout required=done", i); end
            iStart = 1'b0;
            tick();
        end
    endtask

    task automatic test_held_request();
        int p0;
        bit ok;
        bit quiet = 1'b1;
        p0 = enPulses;
        start(8'h0C, 1'b0);
        wait_done(ok);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (oBusy !== 1'b0 || LCD_EN !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!ok || !quiet || enPulses - p0 !== 1) begin
            failures++;
            $display("FAIL held_single got done=%b quiet=%b pulses=%0d required 1/1/1", ok, quiet, enPulses - p0);
        end
        iStart = 1'b0;
        tick();
        start(8'h06, 1'b0);
        wait_done(ok);
        checks++;
        if (!ok || enPulses - p0 !== 2) begin
            failures++;
            $display("FAIL held_rearm got done=%b pulses=%0d required 1/2", ok, enPulses - p0);
        end
        iStart = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        int  d0;
        bit  ok;
        exp_t junk;
        start(8'h52, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (LCD_EN !== 1'b1) begin failures++; $display("FAIL midrst_en_hi got=%b required=1", LCD_EN); end
        iRST = 1'b1;
        iStart = 1'b0;
        junk = sbq.pop_back();
        tick();
        iRST = 1'b0;
        checks++;
        if (LCD_EN !== 1'b0 || oBusy !== 1'b0 || LCD_DATA !== 8'h00 || LCD_RS !== 1'b0) begin
            failures++;
            $display("FAIL midrst_after got en=%b busy=%b data=%h rs=%b required 0/0/00/0",
                     LCD_EN, oBusy, LCD_DATA, LCD_RS);
        end
        d0 = doneCount;
        for (int k = 0; k < 60; k++) tick();
        checks++;
        if (doneCount !== d0) begin
            failures++;
            $display("FAIL midrst_no_done got=%0d required=0", doneCount - d0);
        end
        start(8'h48, 1'b1);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL midrst_recover got=timeout required=done"); end
        iStart = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] seqTab[5] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
        int p0, d0;
        bit ok;
        bit allOk = 1'b1;
        p0 = enPulses;
        d0 = doneCount;
        for (int i = 0; i < 5; i++) begin
            start(seqTab[i], 1'b0);
            wait_done(ok);
            if (!ok) allOk = 1'b0;
            iStart = 1'b0;
            tick();
        end
        checks++;
        if (!allOk || enPulses - p0 !== 5 || doneCount - d0 !== 5) begin
            failures++;
            $display("FAIL b2b_counts got ok=%b pulses=%0d dones=%0d required 1/5/5",
                     allOk, enPulses - p0, doneCount - d0);
        end
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_exec_length();
        test_held_request();
        test_mid_reset();
        test_back_to_back();
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (sbq.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
